// File: rtl/projectile_pool_if.sv
// Spawn handshake, kill mask, control strobes and pool status bundle for projectile_pool.
// The master drives the i_* requests and the slave (the pool) drives the o_* status.
interface projectile_pool_if #(
    parameter int N_SLOTS = 8,
    parameter int X_W     = 10,
    parameter int Y_W     = 9
);
    localparam int F_W = $clog2(N_SLOTS + 1);

    logic                         i_Enable;
    logic                         i_Clear;
    logic                         i_Tick;
    logic                         i_SpawnReq;
    logic [X_W-1:0]               i_SpawnX;
    logic [Y_W-1:0]               i_SpawnY;
    logic                         o_SpawnAck;
    logic [N_SLOTS-1:0]           i_KillMask;
    logic [N_SLOTS-1:0]           o_Active;
    logic [N_SLOTS*(X_W+Y_W)-1:0] o_PosFlat;
    logic [F_W-1:0]               o_FreeCnt;
    logic                         o_Full;
    logic                         o_Busy;

    modport master (
        output i_Enable, i_Clear, i_Tick, i_SpawnReq, i_SpawnX, i_SpawnY, i_KillMask,
        input  o_SpawnAck, o_Active, o_PosFlat, o_FreeCnt, o_Full, o_Busy
    );

    modport slave (
        input  i_Enable, i_Clear, i_Tick, i_SpawnReq, i_SpawnX, i_SpawnY, i_KillMask,
        output o_SpawnAck, o_Active, o_PosFlat, o_FreeCnt, o_Full, o_Busy
    );
endinterface

// File: rtl/projectile_pool.sv
// Projectile slot pool: spawn into lowest free slot, move on frame tick, retire on bound or kill.
// All state updates appear one clock after the edge; o_SpawnAck is combinational and low while full or cooling down.
module projectile_pool #(
    parameter int N_SLOTS  = 8,
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int STEP     = 4,
    parameter int Y_MAX    = 479,
    parameter int DIR_UP   = 1,
    parameter int COOLDOWN = 8
) (
    input logic              i_Clk,
    input logic              i_Rst,
    projectile_pool_if.slave bus
);
    localparam int P_W = X_W + Y_W;
    localparam int C_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
    localparam int F_W = $clog2(N_SLOTS + 1);

    localparam logic [Y_W:0]   STEP_E  = (Y_W + 1)'(STEP);
    localparam logic [Y_W:0]   YMAX_E  = (Y_W + 1)'(Y_MAX);
    localparam logic [C_W-1:0] COOL_LD = C_W'(COOLDOWN);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pos_t;

    state_t             state_q;
    logic               busy_q;
    logic [N_SLOTS-1:0] active_q, active_d;
    pos_t               pos_q [N_SLOTS];
    pos_t               pos_d [N_SLOTS];
    logic [C_W-1:0]     cool_q, cool_d;

    logic [F_W-1:0]     free_cnt;
    logic               full;
    logic               run;
    logic               wipe;
    logic               move;
    logic               spawn_ack;
    logic               found;
    logic [N_SLOTS-1:0] spawn_oh;
    logic [Y_W:0]       y_ext;
    logic [Y_W:0]       y_nx;
    logic               retire;

    always_comb begin
        free_cnt = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            free_cnt = free_cnt + F_W'(!active_q[k]);
        end
    end

    assign full      = (free_cnt == '0);
    assign run       = (state_q == RUN);
    assign wipe      = bus.i_Clear | (state_q == FLUSH);
    assign move      = run & bus.i_Tick;
    assign spawn_ack = bus.i_SpawnReq & run & ~full & (cool_q == '0) & ~bus.i_Clear;

    // Slot choice uses registered occupancy, so a slot freed this cycle waits a cycle.
    always_comb begin
        spawn_oh = '0;
        found    = 1'b0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (!active_q[k] && !found) begin
                spawn_oh[k] = spawn_ack;
                found       = 1'b1;
            end
        end
    end

    always_comb begin
        active_d = active_q;
        y_ext    = '0;
        y_nx     = '0;
        retire   = 1'b0;
        for (int k = 0; k < N_SLOTS; k++) begin
            pos_d[k] = pos_q[k];
        end
        for (int k = 0; k < N_SLOTS; k++) begin
            y_ext  = {1'b0, pos_q[k].y};
            y_nx   = (DIR_UP != 0) ? (y_ext - STEP_E) : (y_ext + STEP_E);
            retire = (DIR_UP != 0) ? (y_ext < STEP_E) : (y_nx > YMAX_E);
            if (wipe) begin
                active_d[k] = 1'b0;
                pos_d[k]    = '0;
            end else if (spawn_oh[k]) begin
                active_d[k] = 1'b1;
                pos_d[k]    = {bus.i_SpawnX, bus.i_SpawnY};
            end else if (active_q[k]) begin
                // Kill outranks movement; a retired slot keeps its stale position.
                if (bus.i_KillMask[k]) begin
                    active_d[k] = 1'b0;
                end else if (move) begin
                    if (retire) begin
                        active_d[k] = 1'b0;
                    end else begin
                        pos_d[k].y = y_nx[Y_W-1:0];
                    end
                end
            end
        end
    end

    always_comb begin
        cool_d = cool_q;
        if (wipe) begin
            cool_d = '0;
        end else if (spawn_ack) begin
            cool_d = COOL_LD;
        end else if (move && (cool_q != '0)) begin
            cool_d = cool_q - C_W'(1);
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            active_q <= '0;
            cool_q   <= '0;
            for (int k = 0; k < N_SLOTS; k++) begin
                pos_q[k] <= '0;
            end
        end else begin
            active_q <= active_d;
            cool_q   <= cool_d;
            for (int k = 0; k < N_SLOTS; k++) begin
                pos_q[k] <= pos_d[k];
            end
        end
    end

    // Clear outranks enable from every state; FLUSH lasts exactly one cycle unless clear is held.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, RUN, FLUSH: begin
                    if (bus.i_Clear) begin
                        state_q <= FLUSH;
                        busy_q  <= 1'b1;
                    end else if (bus.i_Enable) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_pos
        assign bus.o_PosFlat[g*P_W +: P_W] = pos_q[g];
    end

    assign bus.o_Active   = active_q;
    assign bus.o_FreeCnt  = free_cnt;
    assign bus.o_Full     = full;
    assign bus.o_Busy     = busy_q;
    assign bus.o_SpawnAck = spawn_ack;
endmodule

// File: tb/tb_projectile_pool.sv
// Directed bench: three pool configurations (8 slots up, 2 slots up, 8 slots down with cooldown 3).
module tb_projectile_pool;
    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    projectile_pool_if #(.N_SLOTS(8), .X_W(10), .Y_W(9)) a_if ();
    projectile_pool_if #(.N_SLOTS(2), .X_W(10), .Y_W(9)) b_if ();
    projectile_pool_if #(.N_SLOTS(8), .X_W(10), .Y_W(9)) c_if ();

    projectile_pool #(.N_SLOTS(8), .X_W(10), .Y_W(9), .STEP(4), .Y_MAX(479), .DIR_UP(1), .COOLDOWN(0))
        dut_a (.i_Clk(clk), .i_Rst(rst_a), .bus(a_if));
    projectile_pool #(.N_SLOTS(2), .X_W(10), .Y_W(9), .STEP(4), .Y_MAX(479), .DIR_UP(1), .COOLDOWN(0))
        dut_b (.i_Clk(clk), .i_Rst(rst_b), .bus(b_if));
    projectile_pool #(.N_SLOTS(8), .X_W(10), .Y_W(9), .STEP(4), .Y_MAX(479), .DIR_UP(0), .COOLDOWN(3))
        dut_c (.i_Clk(clk), .i_Rst(rst_c), .bus(c_if));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_if.i_SpawnReq = 1'b1;
        #1;
        checks++; if (a_if.o_SpawnAck !== 1'b0) begin errors++; $display("FAIL rst_ack got %0h want 0", a_if.o_SpawnAck); end
        checks++; if (a_if.o_Active !== 8'h00) begin errors++; $display("FAIL rst_active got %0h want 00", a_if.o_Active); end
        checks++; if (a_if.o_FreeCnt !== 4'd8) begin errors++; $display("FAIL rst_freecnt got %0d want 8", a_if.o_FreeCnt); end
        checks++; if (a_if.o_Full !== 1'b0 || a_if.o_Busy !== 1'b0) begin errors++; $display("FAIL rst_full_busy got %0h%0h want 00", a_if.o_Full, a_if.o_Busy); end
        checks++; if (b_if.o_FreeCnt !== 2'd2) begin errors++; $display("FAIL rst_freecnt_b got %0d want 2", b_if.o_FreeCnt); end
        checks++; if (a_if.o_PosFlat !== '0) begin errors++; $display("FAIL rst_pos got %0h want 0", a_if.o_PosFlat); end
        a_if.i_SpawnReq = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        a_if.i_Enable = 1'b1;
        cyc();
        checks++; if (a_if.o_Busy !== 1'b1) begin errors++; $display("FAIL run_busy got %0h want 1", a_if.o_Busy); end
        a_if.i_SpawnReq = 1'b1; a_if.i_SpawnX = 10'd10; a_if.i_SpawnY = 9'd200;
        cyc();
        cyc();
        cyc();
        a_if.i_SpawnReq = 1'b0;
        #1;
        checks++; if (a_if.o_Active !== 8'h07 || a_if.o_FreeCnt !== 4'd5) begin errors++; $display("FAIL three_live got %0h/%0d want 07/5", a_if.o_Active, a_if.o_FreeCnt); end
        rst_a = 1'b1;
        #1;
        checks++; if (a_if.o_Active !== 8'h00 || a_if.o_FreeCnt !== 4'd8) begin errors++; $display("FAIL midrst got %0h/%0d want 00/8", a_if.o_Active, a_if.o_FreeCnt); end
        checks++; if (a_if.o_Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0h want 0", a_if.o_Busy); end
        rst_a = 1'b0;
        cyc();
        a_if.i_SpawnReq = 1'b1;
        #1;
        checks++; if (a_if.o_SpawnAck !== 1'b1) begin errors++; $display("FAIL post_rst_ack got %0h want 1", a_if.o_SpawnAck); end
        a_if.i_SpawnReq = 1'b0;
    endtask

    task automatic test_spawn_move();
        a_if.i_SpawnReq = 1'b1; a_if.i_SpawnX = 10'd100; a_if.i_SpawnY = 9'd400;
        #1;
        checks++; if (a_if.o_SpawnAck !== 1'b1) begin errors++; $display("FAIL t2_ack got %0h want 1", a_if.o_SpawnAck); end
        cyc();
        a_if.i_SpawnReq = 1'b0;
        checks++; if (a_if.o_Active !== 8'h01 || a_if.o_PosFlat[18:0] !== {10'd100, 9'd400}) begin errors++; $display("FAIL t2_spawn got %0h/%0h want 01/%0h", a_if.o_Active, a_if.o_PosFlat[18:0], {10'd100, 9'd400}); end
        a_if.i_Tick = 1'b1;
        cyc();
        a_if.i_Tick = 1'b0;
        checks++; if (a_if.o_PosFlat[18:0] !== {10'd100, 9'd396}) begin errors++; $display("FAIL t2_move1 got %0h want %0h", a_if.o_PosFlat[18:0], {10'd100, 9'd396}); end
        a_if.i_Tick = 1'b1;
        cyc();
        a_if.i_Tick = 1'b0;
        checks++; if (a_if.o_PosFlat[18:0] !== {10'd100, 9'd392}) begin errors++; $display("FAIL t2_move2 got %0h want %0h", a_if.o_PosFlat[18:0], {10'd100, 9'd392}); end
        a_if.i_Enable = 1'b0;
        cyc();
        a_if.i_Tick = 1'b1; a_if.i_SpawnReq = 1'b1;
        #1;
        checks++; if (a_if.o_SpawnAck !== 1'b0) begin errors++; $display("FAIL idle_ack got %0h want 0", a_if.o_SpawnAck); end
        cyc();
        a_if.i_Tick = 1'b0; a_if.i_SpawnReq = 1'b0;
        checks++; if (a_if.o_PosFlat[18:0] !== {10'd100, 9'd392} || a_if.o_Active !== 8'h01 || a_if.o_Busy !== 1'b0) begin errors++; $display("FAIL idle_freeze got %0h/%0h/%0h want %0h/01/0", a_if.o_PosFlat[18:0], a_if.o_Active, a_if.o_Busy, {10'd100, 9'd392}); end
        a_if.i_Enable = 1'b1;
        cyc();
    endtask

    task automatic test_simultaneous();
        a_if.i_SpawnReq = 1'b1; a_if.i_SpawnX = 10'd50; a_if.i_SpawnY = 9'd300;
        cyc();
        a_if.i_SpawnX = 10'd60; a_if.i_SpawnY = 9'd200;
        cyc();
        a_if.i_SpawnReq = 1'b0; a_if.i_KillMask = 8'h02;
        cyc();
        a_if.i_KillMask = 8'h00;
        checks++; if (a_if.o_Active !== 8'h05) begin errors++; $display("FAIL kill1 got %0h want 05", a_if.o_Active); end
        a_if.i_Tick = 1'b1; a_if.i_KillMask = 8'h01;
        a_if.i_SpawnReq = 1'b1; a_if.i_SpawnX = 10'd7; a_if.i_SpawnY = 9'd77;
        #1;
        checks++; if (a_if.o_SpawnAck !== 1'b1) begin errors++; $display("FAIL t5_ack got %0h want 1", a_if.o_SpawnAck); end
        cyc();
        a_if.i_Tick = 1'b0; a_if.i_KillMask = 8'h00; a_if.i_SpawnReq = 1'b0;
        checks++; if (a_if.o_Active !== 8'h06) begin errors++; $display("FAIL t5_active got %0h want 06", a_if.o_Active); end
        checks++; if (a_if.o_PosFlat[37:19] !== {10'd7, 9'd77}) begin errors++; $display("FAIL t5_spawn_pos got %0h want %0h", a_if.o_PosFlat[37:19], {10'd7, 9'd77}); end
        checks++; if (a_if.o_PosFlat[56:38] !== {10'd60, 9'd196}) begin errors++; $display("FAIL t5_moved got %0h want %0h", a_if.o_PosFlat[56:38], {10'd60, 9'd196}); end
        a_if.i_SpawnReq = 1'b1; a_if.i_SpawnX = 10'd9; a_if.i_SpawnY = 9'd99; a_if.i_KillMask = 8'h01;
        cyc();
        a_if.i_SpawnReq = 1'b0; a_if.i_KillMask = 8'h00;
        checks++; if (a_if.o_Active !== 8'h07 || a_if.o_PosFlat[18:0] !== {10'd9, 9'd99}) begin errors++; $display("FAIL spawn_beats_kill got %0h/%0h want 07/%0h", a_if.o_Active, a_if.o_PosFlat[18:0], {10'd9, 9'd99}); end
        a_if.i_SpawnReq = 1'b1; a_if.i_SpawnX = 10'd11; a_if.i_SpawnY = 9'd111; a_if.i_KillMask = 8'h01;
        cyc();
        a_if.i_SpawnReq = 1'b0; a_if.i_KillMask = 8'h00;
        checks++; if (a_if.o_Active !== 8'h0E || a_if.o_PosFlat[75:57] !== {10'd11, 9'd111}) begin errors++; $display("FAIL no_reuse got %0h/%0h want 0e/%0h", a_if.o_Active, a_if.o_PosFlat[75:57], {10'd11, 9'd111}); end
        checks++; if (a_if.o_FreeCnt !== 4'd5) begin errors++; $display("FAIL t5_freecnt got %0d want 5", a_if.o_FreeCnt); end
    endtask

    task automatic test_full_bound();
        b_if.i_Enable = 1'b1;
        cyc();
        b_if.i_SpawnReq = 1'b1; b_if.i_SpawnX = 10'd1; b_if.i_SpawnY = 9'd3;
        cyc();
        b_if.i_SpawnX = 10'd2; b_if.i_SpawnY = 9'd100;
        cyc();
        b_if.i_SpawnX = 10'd5; b_if.i_SpawnY = 9'd50;
        #1;
        checks++; if (b_if.o_Full !== 1'b1 || b_if.o_FreeCnt !== 2'd0) begin errors++; $display("FAIL t4_full got %0h/%0d want 1/0", b_if.o_Full, b_if.o_FreeCnt); end
        checks++; if (b_if.o_SpawnAck !== 1'b0) begin errors++; $display("FAIL t4_full_ack got %0h want 0", b_if.o_SpawnAck); end
        b_if.i_Tick = 1'b1;
        cyc();
        b_if.i_Tick = 1'b0;
        #1;
        checks++; if (b_if.o_Active !== 2'b10 || b_if.o_Full !== 1'b0) begin errors++; $display("FAIL t4_retire got %0h/%0h want 2/0", b_if.o_Active, b_if.o_Full); end
        checks++; if (b_if.o_SpawnAck !== 1'b1) begin errors++; $display("FAIL t4_reack got %0h want 1", b_if.o_SpawnAck); end
        cyc();
        b_if.i_SpawnReq = 1'b0;
        checks++; if (b_if.o_Active !== 2'b11 || b_if.o_PosFlat[18:0] !== {10'd5, 9'd50} || b_if.o_PosFlat[37:19] !== {10'd2, 9'd96}) begin errors++; $display("FAIL t4_refill got %0h/%0h want 3/%0h", b_if.o_Active, b_if.o_PosFlat, {10'd2, 9'd96, 10'd5, 9'd50}); end
        b_if.i_KillMask = 2'b10;
        cyc();
        b_if.i_KillMask = 2'b00;
        b_if.i_SpawnReq = 1'b1; b_if.i_SpawnX = 10'd6; b_if.i_SpawnY = 9'd4;
        cyc();
        b_if.i_SpawnReq = 1'b0; b_if.i_Tick = 1'b1;
        cyc();
        checks++; if (b_if.o_Active !== 2'b11 || b_if.o_PosFlat[37:19] !== {10'd6, 9'd0} || b_if.o_PosFlat[18:0] !== {10'd5, 9'd46}) begin errors++; $display("FAIL t4_y4_to_0 got %0h/%0h want 3/%0h", b_if.o_Active, b_if.o_PosFlat, {10'd6, 9'd0, 10'd5, 9'd46}); end
        cyc();
        b_if.i_Tick = 1'b0;
        checks++; if (b_if.o_Active !== 2'b01 || b_if.o_PosFlat[18:0] !== {10'd5, 9'd42}) begin errors++; $display("FAIL t4_y0_retire got %0h/%0h want 1/%0h", b_if.o_Active, b_if.o_PosFlat[18:0], {10'd5, 9'd42}); end
    endtask

    task automatic test_cooldown();
        c_if.i_Enable = 1'b1;
        cyc();
        c_if.i_SpawnReq = 1'b1; c_if.i_SpawnX = 10'd20; c_if.i_SpawnY = 9'd10;
        #1;
        checks++; if (c_if.o_SpawnAck !== 1'b1) begin errors++; $display("FAIL t3_first_ack got %0h want 1", c_if.o_SpawnAck); end
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (c_if.o_SpawnAck !== 1'b0) begin errors++; $display("FAIL t3_wait_%0d got %0h want 0", i, c_if.o_SpawnAck); end
            c_if.i_Tick = 1'b1;
            #1;
            checks++; if (c_if.o_SpawnAck !== 1'b0) begin errors++; $display("FAIL t3_tick_%0d got %0h want 0", i, c_if.o_SpawnAck); end
            cyc();
            c_if.i_Tick = 1'b0;
        end
        #1;
        checks++; if (c_if.o_SpawnAck !== 1'b1) begin errors++; $display("FAIL t3_release got %0h want 1", c_if.o_SpawnAck); end
        c_if.i_Tick = 1'b1;
        cyc();
        c_if.i_Tick = 1'b0;
        #1;
        checks++; if (c_if.o_SpawnAck !== 1'b0 || c_if.o_Active !== 8'h03) begin errors++; $display("FAIL t3_second got %0h/%0h want 0/03", c_if.o_SpawnAck, c_if.o_Active); end
        checks++; if (c_if.o_PosFlat[37:0] !== {10'd20, 9'd10, 10'd20, 9'd26}) begin errors++; $display("FAIL t3_pos got %0h want %0h", c_if.o_PosFlat[37:0], {10'd20, 9'd10, 10'd20, 9'd26}); end
        for (int i = 0; i < 2; i++) begin
            c_if.i_Tick = 1'b1;
            cyc();
            c_if.i_Tick = 1'b0;
            #1;
            checks++; if (c_if.o_SpawnAck !== 1'b0) begin errors++; $display("FAIL t3_load_wins_%0d got %0h want 0", i, c_if.o_SpawnAck); end
        end
        c_if.i_Tick = 1'b1;
        cyc();
        c_if.i_Tick = 1'b0;
        #1;
        checks++; if (c_if.o_SpawnAck !== 1'b1) begin errors++; $display("FAIL t3_third_ack got %0h want 1", c_if.o_SpawnAck); end
        c_if.i_SpawnReq = 1'b0;
        checks++; if (c_if.o_PosFlat[37:19] !== {10'd20, 9'd22}) begin errors++; $display("FAIL t3_down_move got %0h want %0h", c_if.o_PosFlat[37:19], {10'd20, 9'd22}); end
        c_if.i_SpawnReq = 1'b1;
        cyc();
        c_if.i_SpawnReq = 1'b0;
        rst_c = 1'b1;
        #1;
        rst_c = 1'b0;
        cyc();
        c_if.i_SpawnReq = 1'b1;
        #1;
        checks++; if (c_if.o_SpawnAck !== 1'b1 || c_if.o_Active !== 8'h00) begin errors++; $display("FAIL rst_cool got %0h/%0h want 1/00", c_if.o_SpawnAck, c_if.o_Active); end
        c_if.i_SpawnReq = 1'b0;
    endtask

    task automatic test_flush_down();
        for (int i = 0; i < 5; i++) begin
            c_if.i_SpawnReq = 1'b1; c_if.i_SpawnX = 10'(i); c_if.i_SpawnY = 9'd50;
            cyc();
            c_if.i_SpawnReq = 1'b0;
            if (i < 4) begin
                c_if.i_Tick = 1'b1;
                repeat (3) cyc();
                c_if.i_Tick = 1'b0;
            end
        end
        checks++; if (c_if.o_Active !== 8'h1F || c_if.o_FreeCnt !== 4'd3) begin errors++; $display("FAIL t6_five got %0h/%0d want 1f/3", c_if.o_Active, c_if.o_FreeCnt); end
        c_if.i_Clear = 1'b1; c_if.i_SpawnReq = 1'b1;
        #1;
        checks++; if (c_if.o_SpawnAck !== 1'b0) begin errors++; $display("FAIL t6_clear_ack got %0h want 0", c_if.o_SpawnAck); end
        cyc();
        c_if.i_Clear = 1'b0; c_if.i_SpawnReq = 1'b0;
        checks++; if (c_if.o_Active !== 8'h00 || c_if.o_FreeCnt !== 4'd8 || c_if.o_Busy !== 1'b1) begin errors++; $display("FAIL t6_flush got %0h/%0d/%0h want 00/8/1", c_if.o_Active, c_if.o_FreeCnt, c_if.o_Busy); end
        checks++; if (c_if.o_PosFlat !== '0) begin errors++; $display("FAIL t6_flush_pos got %0h want 0", c_if.o_PosFlat); end
        cyc();
        c_if.i_SpawnReq = 1'b1; c_if.i_SpawnX = 10'd33; c_if.i_SpawnY = 9'd475;
        #1;
        checks++; if (c_if.o_SpawnAck !== 1'b1) begin errors++; $display("FAIL t6_run_ack got %0h want 1", c_if.o_SpawnAck); end
        cyc();
        c_if.i_SpawnReq = 1'b0; c_if.i_Tick = 1'b1;
        cyc();
        checks++; if (c_if.o_Active !== 8'h01 || c_if.o_PosFlat[18:0] !== {10'd33, 9'd479}) begin errors++; $display("FAIL t6_at_max got %0h/%0h want 01/%0h", c_if.o_Active, c_if.o_PosFlat[18:0], {10'd33, 9'd479}); end
        cyc();
        checks++; if (c_if.o_Active !== 8'h00) begin errors++; $display("FAIL t6_past_max got %0h want 00", c_if.o_Active); end
        cyc();
        c_if.i_Tick = 1'b0; c_if.i_SpawnReq = 1'b1; c_if.i_SpawnY = 9'd477;
        cyc();
        c_if.i_SpawnReq = 1'b0; c_if.i_Tick = 1'b1;
        checks++; if (c_if.o_Active !== 8'h01 || c_if.o_PosFlat[18:0] !== {10'd33, 9'd477}) begin errors++; $display("FAIL t6_spawn477 got %0h/%0h want 01/%0h", c_if.o_Active, c_if.o_PosFlat[18:0], {10'd33, 9'd477}); end
        cyc();
        c_if.i_Tick = 1'b0;
        checks++; if (c_if.o_Active !== 8'h00) begin errors++; $display("FAIL t6_477_retire got %0h want 00", c_if.o_Active); end
        c_if.i_Enable = 1'b0; c_if.i_Clear = 1'b1;
        cyc();
        c_if.i_Clear = 1'b0;
        cyc();
        checks++; if (c_if.o_Busy !== 1'b0) begin errors++; $display("FAIL t6_flush_idle got %0h want 0", c_if.o_Busy); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        a_if.i_Enable = 1'b0; a_if.i_Clear = 1'b0; a_if.i_Tick = 1'b0; a_if.i_SpawnReq = 1'b0;
        a_if.i_SpawnX = '0; a_if.i_SpawnY = '0; a_if.i_KillMask = '0;
        b_if.i_Enable = 1'b0; b_if.i_Clear = 1'b0; b_if.i_Tick = 1'b0; b_if.i_SpawnReq = 1'b0;
        b_if.i_SpawnX = '0; b_if.i_SpawnY = '0; b_if.i_KillMask = '0;
        c_if.i_Enable = 1'b0; c_if.i_Clear = 1'b0; c_if.i_Tick = 1'b0; c_if.i_SpawnReq = 1'b0;
        c_if.i_SpawnX = '0; c_if.i_SpawnY = '0; c_if.i_KillMask = '0;
        repeat (2) cyc();
        test_reset();
        test_spawn_move();
        test_simultaneous();
        test_full_bound();
        test_cooldown();
        test_flush_down();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
